masku_result_acc: RTL and testbench

MASKU_RESULT_ACC -- requirements
Module: masku_result_acc

---
 rtl/masku_result_acc_if.sv | 52 +++++
 rtl/masku_result_acc.sv | 170 +++++++++++++++++
 tb/tb_masku_result_acc.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/masku_result_acc_if.sv
// Handshake and data bundle between the mask-unit operand stage, the
// result accumulator and the lane write-back path.
interface masku_result_acc_if #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned VlWidth = 16
);
  localparam int unsigned DW = NrLanes * 64;
  localparam int unsigned PW = $clog2(DW) + 1;

  // Instruction setup
  logic               start_i;
  logic [VlWidth-1:0] vl_i;
  logic [1:0]         vsew_i;

  // Compressed beat input
  logic               op_valid_i;
  logic               op_ready_o;
  logic [DW-1:0]      alu_result_compressed_i;
  logic [DW-1:0]      bit_enable_i;
  logic [PW-1:0]      vrf_pnt_o;

  // Result word output
  logic               res_valid_o;
  logic               res_ready_i;
  logic [DW-1:0]      res_data_o;
  logic [DW-1:0]      res_be_o;
  logic               res_last_o;

  // Status
  logic               busy_o;
  logic               done_o;

  // Upstream / write-back side (drives beats, consumes words)
  modport master (
    output start_i, vl_i, vsew_i,
    output op_valid_i, alu_result_compressed_i, bit_enable_i,
    output res_ready_i,
    input  op_ready_o, vrf_pnt_o,
    input  res_valid_o, res_data_o, res_be_o, res_last_o,
    input  busy_o, done_o
  );

  // Accumulator side
  modport slave (
    input  start_i, vl_i, vsew_i,
    input  op_valid_i, alu_result_compressed_i, bit_enable_i,
    input  res_ready_i,
    output op_ready_o, vrf_pnt_o,
    output res_valid_o, res_data_o, res_be_o, res_last_o,
    output busy_o, done_o
  );
endinterface

// File: rtl/masku_result_acc.sv
// Mask-unit result accumulator: gathers compressed 1-bit-per-element compare
// results, beat by beat, into a DW-wide mask word and hands each full (or
// final partial) word to the lane write-back path.
module masku_result_acc #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned VlWidth = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  masku_result_acc_if.slave bus
);
  localparam int unsigned ELEN = 64;
  localparam int unsigned DW   = NrLanes * ELEN;
  localparam int unsigned PW   = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e             state_r;
  state_e             next_state_s;

  logic [VlWidth-1:0] vl_r;
  logic [1:0]         vsew_r;
  logic [VlWidth-1:0] elem_cnt_r;
  logic [PW-1:0]      vrf_pnt_r;
  logic [DW-1:0]      acc_data_r;
  logic [DW-1:0]      acc_be_r;
  logic               last_r;
  logic               done_zero_r;

  logic [VlWidth-1:0] bpb_s;
  logic [VlWidth-1:0] remain_s;
  logic [VlWidth-1:0] n_s;
  logic [VlWidth-1:0] elem_sum_s;
  logic [PW-1:0]      pnt_sum_s;
  logic               last_beat_s;
  logic               word_full_s;
  logic               accept_s;
  logic               flush_hs_s;
  logic               start_go_s;
  logic               start_zero_s;
  logic               op_ready_s;
  logic               res_valid_s;
  logic               busy_s;

  // Beat sizing: elements per beat from the latched SEW, clipped to what remains of vl.
  always_comb begin
    bpb_s       = VlWidth'(DW >> (32'd3 + 32'(vsew_r)));
    remain_s    = vl_r - elem_cnt_r;
    if (bpb_s < remain_s) begin
      n_s = bpb_s;
    end else begin
      n_s = remain_s;
    end
    elem_sum_s  = elem_cnt_r + n_s;
    pnt_sum_s   = vrf_pnt_r + PW'(n_s);
    last_beat_s = (elem_sum_s == vl_r);
    word_full_s = (pnt_sum_s == PW'(DW));
  end

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept_s     = (state_r == ACCUM) && bus.op_valid_i;
    flush_hs_s   = (state_r == FLUSH) && bus.res_ready_i;
    start_go_s   = (state_r == IDLE) && bus.start_i && (bus.vl_i != '0);
    start_zero_s = (state_r == IDLE) && bus.start_i && (bus.vl_i == '0);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    next_state_s = state_r;
    op_ready_s   = 1'b0;
    res_valid_s  = 1'b0;
    busy_s       = 1'b1;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start_go_s) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        op_ready_s = 1'b1;
        if (bus.op_valid_i && (word_full_s || last_beat_s)) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = ACCUM;
        end
      end
      FLUSH: begin
        res_valid_s = 1'b1;
        if (bus.res_ready_i && last_r) begin
          next_state_s = IDLE;
        end else if (bus.res_ready_i) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = FLUSH;
        end
      end
      default: begin
        next_state_s = IDLE;
        busy_s       = 1'b0;
      end
    endcase
  end

  // Accumulation datapath: latch on start, OR in beats, clear the word on hand-off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vl_r        <= '0;
      vsew_r      <= 2'd0;
      elem_cnt_r  <= '0;
      vrf_pnt_r   <= '0;
      acc_data_r  <= '0;
      acc_be_r    <= '0;
      last_r      <= 1'b0;
      done_zero_r <= 1'b0;
    end else begin
      done_zero_r <= start_zero_s;
      if (start_go_s) begin
        vl_r       <= bus.vl_i;
        vsew_r     <= bus.vsew_i;
        elem_cnt_r <= '0;
        vrf_pnt_r  <= '0;
        acc_data_r <= '0;
        acc_be_r   <= '0;
        last_r     <= 1'b0;
      end else if (accept_s) begin
        acc_data_r <= acc_data_r | (bus.alu_result_compressed_i & bus.bit_enable_i);
        acc_be_r   <= acc_be_r | bus.bit_enable_i;
        elem_cnt_r <= elem_sum_s;
        vrf_pnt_r  <= pnt_sum_s;
        last_r     <= last_beat_s;
      end else if (flush_hs_s) begin
        acc_data_r <= '0;
        acc_be_r   <= '0;
        vrf_pnt_r  <= '0;
        last_r     <= 1'b0;
      end
    end
  end

  // Output drive: data path straight from registers, done pulses on the zero-length
  // start (one cycle later) or on the final word's hand-off.
  always_comb begin
    bus.op_ready_o  = op_ready_s;
    bus.res_valid_o = res_valid_s;
    bus.busy_o      = busy_s;
    bus.res_data_o  = acc_data_r;
    bus.res_be_o    = acc_be_r;
    bus.res_last_o  = last_r;
    bus.vrf_pnt_o   = vrf_pnt_r;
    bus.done_o      = done_zero_r | (flush_hs_s & last_r);
  end

endmodule

// File: tb/tb_masku_result_acc.sv
// Randomized directed bench for masku_result_acc (NrLanes=4, DW=256).
// Reference: element e of an instruction lands in word e/256 at bit e%256.
module tb_masku_result_acc;
  localparam int DW = 256;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;
  int   done_cnt;
  bit   r_m  [1024];
  bit   en_m [1024];
  logic [DW-1:0] last_word;

  masku_result_acc_if #(.NrLanes(4), .VlWidth(16)) bus ();

  masku_result_acc #(.NrLanes(4), .VlWidth(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses as seen at each active edge.
  always @(posedge clk) begin
    if (bus.done_o === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.start_i = 1'b0;
    bus.vl_i = 16'd0;
    bus.vsew_i = 2'd0;
    bus.op_valid_i = 1'b0;
    bus.alu_result_compressed_i = '0;
    bus.bit_enable_i = '0;
    bus.res_ready_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_ready"}, bus.op_ready_o, '0);
    chk({tag, "_res_valid"}, bus.res_valid_o, '0);
    chk({tag, "_res_data"}, bus.res_data_o, '0);
    chk({tag, "_res_be"}, bus.res_be_o, '0);
    chk({tag, "_res_last"}, bus.res_last_o, '0);
    chk({tag, "_vrf_pnt"}, bus.vrf_pnt_o, '0);
    chk({tag, "_busy"}, bus.busy_o, '0);
    chk({tag, "_done"}, bus.done_o, '0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // One instruction: vl elements at SEW code sew. ones forces all-ones results and
  // enables; gaps inserts idle cycles with stray start pulses; bp holds res_ready low
  // for bp cycles per word; abort_after>=0 returns after that many beats.
  task automatic run(input int vl, input int sew, input bit ones, input bit gaps,
                     input int bp, input int abort_after);
    int bpb;
    int nb;
    int d0;
    int lo;
    int hi;
    int w;
    int k;
    logic [DW-1:0] d;
    logic [DW-1:0] en;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] exp_be;
    bit is_last;

    bpb = DW >> (3 + sew);
    nb  = (vl + bpb - 1) / bpb;
    d0  = done_cnt;
    for (int e = 0; e < vl; e++) begin
      r_m[e]  = ones ? 1'b1 : 1'($urandom_range(0, 1));
      en_m[e] = ones ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    bus.vl_i = 16'(vl);
    bus.vsew_i = 2'(sew);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;

    for (int b = 0; b < nb; b++) begin
      if (b == abort_after) return;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.start_i = 1'($urandom_range(0, 1));
          bus.vl_i = 16'($urandom_range(0, 900));
          bus.vsew_i = 2'($urandom_range(0, 3));
          bus.alu_result_compressed_i = rand_word();
          bus.bit_enable_i = rand_word();
          @(negedge clk);
        end
        bus.start_i = 1'b0;
      end
      k = 0;
      while (bus.op_ready_o !== 1'b1 && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("op_ready_wait", bus.op_ready_o, 1'b1);
      chk("vrf_pnt", bus.vrf_pnt_o, DW'((b * bpb) % DW));

      lo = b * bpb;
      hi = (lo + bpb < vl) ? lo + bpb : vl;
      d  = rand_word();
      en = '0;
      for (int e = lo; e < hi; e++) begin
        d[e % DW]  = r_m[e];
        en[e % DW] = en_m[e];
      end
      bus.alu_result_compressed_i = d;
      bus.bit_enable_i = en;
      bus.op_valid_i = 1'b1;
      @(negedge clk);
      bus.op_valid_i = 1'b0;
      bus.bit_enable_i = '0;

      if ((hi % DW) == 0 || hi == vl) begin
        is_last = (hi == vl);
        w = (hi - 1) / DW;
        exp_d = '0;
        exp_be = '0;
        for (int e = w * DW; e < hi; e++) begin
          exp_d[e % DW]  = r_m[e] & en_m[e];
          exp_be[e % DW] = en_m[e];
        end
        chk("res_valid", bus.res_valid_o, 1'b1);
        chk("res_data", bus.res_data_o, exp_d);
        chk("res_be", bus.res_be_o, exp_be);
        chk("res_last", bus.res_last_o, DW'(is_last));
        for (int c = 0; c < bp; c++) begin
          bus.op_valid_i = 1'b1;
          bus.start_i = 1'b1;
          bus.alu_result_compressed_i = rand_word();
          bus.bit_enable_i = '1;
          @(negedge clk);
          chk("bp_op_ready", bus.op_ready_o, 1'b0);
          chk("bp_res_valid", bus.res_valid_o, 1'b1);
          chk("bp_res_data", bus.res_data_o, exp_d);
          chk("bp_res_be", bus.res_be_o, exp_be);
          chk("bp_res_last", bus.res_last_o, DW'(is_last));
        end
        bus.op_valid_i = 1'b0;
        bus.start_i = 1'b0;
        bus.bit_enable_i = '0;
        last_word = bus.res_data_o;
        bus.res_ready_i = 1'b1;
        #1;
        chk("done_at_handshake", bus.done_o, DW'(is_last));
        @(negedge clk);
        bus.res_ready_i = 1'b0;
        chk("res_valid_after", bus.res_valid_o, 1'b0);
        chk("vrf_pnt_after", bus.vrf_pnt_o, '0);
        if (is_last) chk("busy_after_last", bus.busy_o, 1'b0);
      end
    end
    chk("done_count", DW'(done_cnt - d0), DW'(1));
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt = 0;
    done_cnt = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // e64, vl=8, all ones, started on the first edge after reset release
    run(8, 3, 1'b1, 1'b0, 0, -1);
    chk("e64_word", last_word, DW'(8'hFF));

    // e8, vl=300: two words, second one 44 bits and last
    run(300, 0, 1'b0, 1'b0, 0, -1);

    // Backpressure of 3 cycles on every word
    run(100, 1, 1'b0, 1'b0, 3, -1);
    run(600, 0, 1'b0, 1'b0, 3, -1);

    // Zero-length instruction
    bus.vl_i = 16'd0;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("vl0_done", bus.done_o, 1'b1);
    chk("vl0_busy", bus.busy_o, 1'b0);
    chk("vl0_res_valid", bus.res_valid_o, 1'b0);
    @(negedge clk);
    chk("vl0_done_drop", bus.done_o, 1'b0);
    chk("vl0_busy2", bus.busy_o, 1'b0);
    chk("vl0_res_valid2", bus.res_valid_o, 1'b0);

    // Reset in the middle of accumulation, then a fresh clean word
    run(256, 0, 1'b1, 1'b0, 0, 3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    run(256, 0, 1'b0, 1'b0, 0, -1);

    // Stray start pulses and idle gaps
    run(300, 0, 1'b0, 1'b1, 1, -1);
    run(37, 2, 1'b0, 1'b1, 2, -1);

    // Random mix
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(1, 700), $urandom_range(0, 3), 1'b0,
          1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
    end

    @(negedge clk);
    chk("final_idle_busy", bus.busy_o, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
